mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, RAM word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, byte-address width in bits.
REQ-003 SHALL have port clock  in  1  the single clock, rising-edge active.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  in  1  request present.
REQ-006 SHALL have port req_ready  out  1  unit can accept a request.
REQ-007 SHALL have port req_store  in  1  1 = store, 0 = load.
REQ-008 SHALL have port req_funct3  in  3  RISC-V width code: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
REQ-009 SHALL have port req_addr  in  ADDR_WIDTH  byte address.
REQ-010 SHALL have port req_wdata  in  DATA_WIDTH  store data, right-aligned.
REQ-011 SHALL have port resp_valid  out  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  out  DATA_WIDTH  extended load result; 0 for stores and errors.
REQ-013 SHALL have port resp_err  out  1  misaligned or illegal funct3, qualified by resp_valid.
REQ-014 SHALL have port wEn  out  1  RAM data-port write enable.
REQ-015 SHALL have port d_address  out  ADDR_WIDTH  RAM byte address, low 2 bits always 0.
REQ-016 SHALL have port d_write_data  out  DATA_WIDTH  RAM write word.
REQ-017 SHALL have port d_read_data  in  DATA_WIDTH  RAM read word, combinational from d_address.

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS, MERGE, DONE; req_ready=1 only in IDLE.
REQ-019 SHALL accept a request when req_valid and req_ready are both 1 at a rising edge, registering all req_* fields.
REQ-020 SHALL go IDLE->DONE with resp_err=1 and no RAM write when an access is misaligned (halfword addr[0]!=0, word addr[1:0]!=0) or funct3 is illegal (011, 11x, or 1xx with store).
REQ-021 SHALL otherwise go IDLE->ACCESS, driving d_address={addr[ADDR_WIDTH-1:2],2'b00} from ACCESS until leaving MERGE.
REQ-022 SHALL for loads, in ACCESS, select byte/half by addr[1:0] (little-endian), sign- or zero-extend per funct3, register into resp_rdata, then go to DONE.
REQ-023 SHALL for SW assert wEn=1 with d_write_data=req_wdata for exactly the ACCESS cycle, then go to DONE.
REQ-024 SHALL for SB/SH capture d_read_data in ACCESS, go to MERGE, assert wEn=1 for exactly the MERGE cycle with only the addressed byte/half lanes replaced, then go to DONE.
REQ-025 SHALL assert resp_valid=1 for exactly the DONE cycle, then return to IDLE; latency acceptance->resp_valid: error 1, load/SW 2, SB/SH 3 cycles.
REQ-026 SHALL keep wEn=0 in IDLE and DONE; d_write_data SHALL be 0 whenever wEn=0.
REQ-027 SHALL ignore req_valid outside IDLE; a request held through DONE is accepted on the next IDLE edge (back-to-back throughput one request per latency+1 cycles).
REQ-028 SHALL hold resp_rdata and resp_err stable from DONE until the next DONE.

Reset
REQ-029 SHALL on reset force state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wEn=0, d_address=0, d_write_data=0, asynchronously.
REQ-030 SHALL abandon any in-flight access when reset asserts mid-operation; a partial SB/SH SHALL produce no write if reset asserts before MERGE.

Structure
REQ-031 SHALL place funct3 constants, FSM state encoding and the misalign/illegal check function in shared package mem_access_pkg.
REQ-032 SHALL instantiate one combinational sub-module load_extend (word, addr[1:0], funct3 -> extended result); store-lane merge stays in the top.

Verification
REQ-033 SHALL cover: SW addr=0x0008 data=0xDEADBEEF -> wEn one cycle, d_address=0x0008, resp_valid 2 cycles after accept, err=0.
REQ-034 SHALL cover: RAM[0x0008]=0xDEADBEEF, SB addr=0x0009 data=0x55 -> written word 0xDEAD55EF, resp_valid 3 cycles after accept.
REQ-035 SHALL cover: RAM[0x0008]=0xDEAD55EF, LB addr=0x000B -> 0xFFFFFFDE; LBU addr=0x000B -> 0x000000DE; LH addr=0x0008 -> 0x000055EF.
REQ-036 SHALL cover: LW addr=0x0006 -> resp_err=1 one cycle after accept, wEn never asserted, resp_rdata=0.
REQ-037 SHALL cover: SH addr=0x000C, reset asserted during ACCESS -> all outputs at reset values immediately, RAM[0x000C] unchanged.
REQ-038 SHALL cover: req_valid held high for two back-to-back LW requests -> second accepted in cycle after first DONE, req_ready=0 in between.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared constants and checks for the data-memory access unit.
// funct3 codes, FSM encoding and request legality test.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_MERGE  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  function automatic logic access_bad(
    input logic       store,
    input logic [2:0] funct3,
    input logic [1:0] lo
  );
    logic illegal;
    logic mis;
    illegal = (funct3 == 3'b011)
           || (funct3[2:1] == 2'b11)
           || (funct3[2] && store);
    mis = ((funct3[1:0] == 2'b01) && lo[0])
       || ((funct3[1:0] == 2'b10) && (lo != 2'b00));
    return illegal || mis;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane select and extension.
// Picks the byte/half at offset (little-endian) and extends per funct3.
import mem_access_pkg::*;

module load_extend #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [1:0]            offset,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] result
);

  logic [DATA_WIDTH-1:0] shifted;

  assign shifted = word >> {offset, 3'b000};

  always_comb begin
    result = word;
    unique case (1'b1)
      funct3 == F3_B:
        result = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      funct3 == F3_H:
        result = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      funct3 == F3_BU:
        result = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      funct3 == F3_HU:
        result = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default:
        result = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the core and a word-wide data RAM.
// Sub-word stores are done as read-modify-write.
import mem_access_pkg::*;

module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  wEn,
  output logic [ADDR_WIDTH-1:0] d_address,
  output logic [DATA_WIDTH-1:0] d_write_data,
  input  logic [DATA_WIDTH-1:0] d_read_data
);

  localparam logic [DATA_WIDTH-1:0] BYTE_MASK =
    {{(DATA_WIDTH-8){1'b0}}, 8'hFF};
  localparam logic [DATA_WIDTH-1:0] HALF_MASK =
    {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF};

  logic [1:0]            state;
  logic                  r_store;
  logic [2:0]            r_f3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_merged;
  logic [DATA_WIDTH-1:0] ext_data;
  logic [DATA_WIDTH-1:0] lane;
  logic [DATA_WIDTH-1:0] merged;
  logic [4:0]            sh;
  logic                  word_store;
  logic                  sub_store;
  logic                  in_ram;

  assign word_store = r_store && (r_f3[1:0] == 2'b10);
  assign sub_store  = r_store && (r_f3[1:0] != 2'b10);
  assign in_ram     = (state == S_ACCESS) || (state == S_MERGE);

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_DONE);
  assign wEn = ((state == S_ACCESS) && word_store)
            || (state == S_MERGE);
  assign d_address = in_ram ? {r_addr[ADDR_WIDTH-1:2], 2'b00}
                            : '0;

  always_comb begin
    d_write_data = '0;
    if ((state == S_ACCESS) && word_store)
      d_write_data = r_wdata;
    else if (state == S_MERGE)
      d_write_data = r_merged;
  end

  // Half stores are aligned, so the byte shift also places halves.
  assign sh     = {r_addr[1:0], 3'b000};
  assign lane   = (r_f3[0] ? HALF_MASK : BYTE_MASK) << sh;
  assign merged = (d_read_data & ~lane)
                | ((r_wdata << sh) & lane);

  load_extend #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ext (
    .word  (d_read_data),
    .offset(r_addr[1:0]),
    .funct3(r_f3),
    .result(ext_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      r_store    <= 1'b0;
      r_f3       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_merged   <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      unique case (1'b1)
        state == S_IDLE: begin
          if (req_valid) begin
            r_store <= req_store;
            r_f3    <= req_funct3;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            if (access_bad(req_store, req_funct3,
                           req_addr[1:0])) begin
              state      <= S_DONE;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state <= S_ACCESS;
            end
          end
        end
        state == S_ACCESS: begin
          if (sub_store) begin
            r_merged <= merged;
            state    <= S_MERGE;
          end else begin
            state      <= S_DONE;
            resp_err   <= 1'b0;
            resp_rdata <= r_store ? '0 : ext_data;
          end
        end
        state == S_MERGE: begin
          state      <= S_DONE;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: RAM model, byte-level reference model
// checked every cycle, plus directed requests with literal results.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [15:0] req_addr = 16'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        wEn;
  logic [15:0] d_address;
  logic [31:0] d_write_data;
  logic [31:0] d_read_data;

  logic [31:0] ram  [0:63];
  logic [31:0] mref [0:63];

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int wen_count = 0;
  int acc_last = 0;

  bit          pending = 0;
  int          k = 0;
  int          e_lat = 0;
  bit          e_err = 0;
  bit          e_wr = 0;
  int          e_widx = 0;
  logic [31:0] e_wword = 0;
  logic [15:0] e_waddr = 0;
  logic [31:0] e_rdata = 0;
  logic [31:0] last_rdata = 0;
  bit          last_err = 0;

  mem_access_unit dut (
    .clock       (clk),
    .reset       (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_store   (req_store),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .wEn         (wEn),
    .d_address   (d_address),
    .d_write_data(d_write_data),
    .d_read_data (d_read_data)
  );

  always #5 clk = ~clk;

  assign d_read_data = ram[d_address[7:2]];

  always @(posedge clk)
    if (wEn) ram[d_address[7:2]] <= d_write_data;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference: what a request must do, from size/offset byte rules.
  task automatic model_accept();
    int sz;
    int off;
    bit legal;
    logic [31:0] word;
    logic [31:0] v;
    sz = 1 << req_funct3[1:0];
    off = int'(req_addr) % 4;
    legal = req_store ? (req_funct3 inside {3'd0, 3'd1, 3'd2})
          : (req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    e_err = !legal || ((int'(req_addr) % sz) != 0);
    e_lat = e_err ? 1 : ((req_store && sz < 4) ? 3 : 2);
    e_wr = !e_err && req_store;
    e_widx = int'(req_addr[7:2]);
    e_waddr = req_addr & 16'hFFFC;
    word = mref[e_widx];
    v = 32'h0;
    e_wword = word;
    if (!e_err && !req_store) begin
      for (int i = 0; i < sz; i++)
        v[8*i +: 8] = word[8*(off+i) +: 8];
      if (!req_funct3[2] && sz < 4 && v[8*sz-1])
        for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
    end
    if (e_wr)
      for (int i = 0; i < sz; i++)
        e_wword[8*(off+i) +: 8] = req_wdata[8*i +: 8];
    e_rdata = v;
    k = 1;
    pending = 1;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (wEn) wen_count++;
    if (rst) begin
      pending = 0;
    end else begin
      if (pending) begin
        if (e_wr && k == e_lat - 1) mref[e_widx] = e_wword;
        if (k == e_lat) pending = 0;
        else k++;
      end
      if (req_valid && req_ready) begin
        model_accept();
        acc_last = cyc;
      end
    end
  end

  always @(negedge clk) begin
    bit dn;
    bit wr;
    if (rst) begin
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_valid", 32'(resp_valid), 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_err", 32'(resp_err), 32'd0);
      chk("rst_wen", 32'(wEn), 32'd0);
      chk("rst_addr", 32'(d_address), 32'd0);
      chk("rst_wdata", d_write_data, 32'd0);
      last_rdata = 0;
      last_err = 0;
    end else begin
      dn = pending && (k == e_lat);
      wr = pending && e_wr && (k == e_lat - 1);
      chk("ready", 32'(req_ready), 32'(!pending));
      chk("resp_valid", 32'(resp_valid), 32'(dn));
      chk("wen", 32'(wEn), 32'(wr));
      if (pending && !e_err && k < e_lat)
        chk("d_address", 32'(d_address), 32'(e_waddr));
      if (wr) chk("d_write_data", d_write_data, e_wword);
      else chk("wdata_idle", d_write_data, 32'd0);
      if (dn) begin
        last_rdata = e_rdata;
        last_err = e_err;
      end
      chk("resp_rdata", resp_rdata, last_rdata);
      chk("resp_err", 32'(resp_err), 32'(last_err));
    end
  end

  task automatic run_req(input bit st, input logic [2:0] f3,
                         input logic [15:0] a, input logic [31:0] wd,
                         input int lat, input logic [31:0] rd,
                         input bit err, input int wens);
    int n;
    int w0;
    @(negedge clk);
    req_valid = 1;
    req_store = st;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = wd;
    w0 = wen_count;
    @(posedge clk);
    #1 req_valid = 0;
    n = 0;
    while (n < 8) begin
      @(negedge clk);
      n++;
      if (resp_valid) break;
    end
    if (!resp_valid) begin
      tests++;
      failed++;
      $display("FAIL timeout: no resp_valid for addr %h", a);
    end
    chk("latency", 32'(n), 32'(lat));
    chk("lit_rdata", resp_rdata, rd);
    chk("lit_err", 32'(resp_err), 32'(err));
    @(posedge clk);
    #1 chk("wen_cycles", 32'(wen_count - w0), 32'(wens));
  endtask

  initial begin
    int a0;
    int n;
    for (int i = 0; i < 64; i++) begin
      ram[i] = 32'h0;
      mref[i] = 32'h0;
    end
    ram[3] = 32'h12345678;
    mref[3] = 32'h12345678;
    #1 rst = 1;
    repeat (2) @(negedge clk);
    #2 rst = 0;

    run_req(1, 3'b010, 16'h0008, 32'hDEADBEEF, 2, 0, 0, 1);
    chk("ram_sw", ram[2], 32'hDEADBEEF);
    run_req(1, 3'b000, 16'h0009, 32'h00000055, 3, 0, 0, 1);
    chk("ram_sb", ram[2], 32'hDEAD55EF);
    run_req(0, 3'b000, 16'h000B, 0, 2, 32'hFFFFFFDE, 0, 0);
    run_req(0, 3'b100, 16'h000B, 0, 2, 32'h000000DE, 0, 0);
    run_req(0, 3'b001, 16'h0008, 0, 2, 32'h000055EF, 0, 0);
    run_req(0, 3'b001, 16'h000A, 0, 2, 32'hFFFFDEAD, 0, 0);
    run_req(0, 3'b101, 16'h000A, 0, 2, 32'h0000DEAD, 0, 0);
    run_req(0, 3'b010, 16'h0008, 0, 2, 32'hDEAD55EF, 0, 0);
    run_req(0, 3'b010, 16'h0006, 0, 1, 0, 1, 0);
    run_req(0, 3'b001, 16'h0009, 0, 1, 0, 1, 0);
    run_req(0, 3'b011, 16'h0008, 0, 1, 0, 1, 0);
    run_req(0, 3'b110, 16'h0008, 0, 1, 0, 1, 0);
    run_req(1, 3'b100, 16'h0008, 32'hFF, 1, 0, 1, 0);
    run_req(1, 3'b010, 16'h0012, 32'h1, 1, 0, 1, 0);
    run_req(1, 3'b001, 16'h000A, 32'hAAAA1234, 3, 0, 0, 1);
    chk("ram_sh", ram[2], 32'h123455EF);
    chk("ram_err_nowrite", ram[4], 32'h0);

    // SH abandoned by reset while in ACCESS.
    @(negedge clk);
    req_valid = 1;
    req_store = 1;
    req_funct3 = 3'b001;
    req_addr = 16'h000C;
    req_wdata = 32'h0000BEEF;
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_valid", 32'(resp_valid), 32'd0);
    chk("abort_rdata", resp_rdata, 32'd0);
    chk("abort_wen", 32'(wEn), 32'd0);
    chk("abort_addr", 32'(d_address), 32'd0);
    chk("abort_wdata", d_write_data, 32'd0);
    req_valid = 0;
    repeat (2) @(negedge clk);
    #2 rst = 0;
    repeat (2) @(posedge clk);
    #1 chk("ram_abort", ram[3], 32'h12345678);

    // Two LW with req_valid held high.
    @(negedge clk);
    req_valid = 1;
    req_store = 0;
    req_funct3 = 3'b010;
    req_addr = 16'h0008;
    @(posedge clk);
    #1 a0 = acc_last;
    req_addr = 16'h000C;
    n = 0;
    while (n < 10 && acc_last == a0) begin
      @(posedge clk);
      #1 n++;
    end
    req_valid = 0;
    chk("b2b_gap", 32'(acc_last - a0), 32'd3);
    n = 0;
    while (n < 8) begin
      @(negedge clk);
      n++;
      if (resp_valid) break;
    end
    chk("b2b_lat", 32'(n), 32'd2);
    chk("b2b_rdata", resp_rdata, 32'h12345678);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
